// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned STOP_BITS   = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// bit_end is registered; bit_end_next_c is the same flag one cycle early.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    bit_end_next_c = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= bit_end_next_c;
    end
  end

  assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx_packet.sv
// 8N1 UART transmitter with a valid/ready byte input and a per-packet done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_packet
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned N_BYTES      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BCNT_W = $clog2(N_BYTES + 1);
  localparam int unsigned IDX_W  = $clog2(UART_DATA_W);

  uart_state_e              state_q, state_d;
  logic [UART_DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [BCNT_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic                     tx_q, tx_d;
  logic                     data_ready_q, data_ready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     accept_c;
  logic                     bit_end;
  logic                     bit_end_next_c;
`ifdef UART_TX_PARITY_EN
  logic                     parity_q, parity_d;
`endif

  assign accept_c = data_valid && data_ready_q;

  // Baud counter is held at zero while idle, so every frame starts on a fresh bit.
  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk            (clk),
    .rst            (rst),
    .clear          (state_q == IDLE),
    .bit_end        (bit_end),
    .bit_end_next_c (bit_end_next_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept_c) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end && (bit_idx_q == IDX_W'(UART_DATA_W - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end && (bit_idx_q == IDX_W'(STOP_BITS - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and next values of the registered outputs, all keyed off state_d.
  always_comb begin
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
    if (accept_c) parity_d = ^data_in;
`endif

    if (accept_c) begin
      shift_d = data_in;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = shift_q >> 1;
    end

    // bit_idx counts data bits in DATA and stop bits in STOP.
    if (state_d != state_q) begin
      bit_idx_d = '0;
    end else if (bit_end) begin
      bit_idx_d = bit_idx_q + IDX_W'(1);
    end

    if ((state_q == STOP) && (state_d == IDLE)) begin
      byte_cnt_d = (byte_cnt_q == BCNT_W'(N_BYTES - 1)) ? '0 : byte_cnt_q + BCNT_W'(1);
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase

    data_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    // Lands on the final cycle of the last stop bit of the packet.
    done_d       = (state_d == STOP) && bit_end_next_c &&
                   (bit_idx_d == IDX_W'(STOP_BITS - 1)) &&
                   (byte_cnt_q == BCNT_W'(N_BYTES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      tx_q         <= 1'b1;
      data_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_q         <= tx_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
